// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds an external combinational full adder one
// bit pair per clock (LSB first) and assembles the sum and carry-out.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;
  logic             w_shift;

  // r_in_ready is only ever set while in IDLE, and stays low through reset
  assign w_accept = in_valid & r_in_ready;
  assign w_shift  = (r_state == SHIFT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    fa_a   = w_shift & r_a_sh[0];
    fa_b   = w_shift & r_b_sh[0];
    fa_cin = w_shift & r_carry;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_s_sh      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
      if (w_accept) begin
        r_a_sh  <= a_in;
        r_b_sh  <= b_in;
        r_carry <= cin_in;
        r_cnt   <= '0;
        r_s_sh  <= '0;
      end else if (w_shift) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_carry <= fa_cout;
        r_s_sh  <= {fa_sum, r_s_sh[WIDTH-1:1]};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // Sum/carry registers are untouched in IDLE, so they hold the last result
  assign sum_out   = r_s_sh;
  assign cout_out  = r_carry;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq at WIDTH=8 and WIDTH=3,
// each driving a behavioural combinational full adder.
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       sel;
  logic       in_valid_m;
  logic       out_ready_m;
  logic       cin_m;
  logic [7:0] a_m;
  logic [7:0] b_m;

  logic       in_ready8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
  logic       out_valid8, cout8, busy8;
  logic [7:0] sum8;
  logic       in_ready3, fa_a3, fa_b3, fa_cin3, fa_sum3, fa_cout3;
  logic       out_valid3, cout3, busy3;
  logic [2:0] sum3;

  logic       m_in_ready;
  logic       m_out_valid;
  logic [8:0] m_res;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_sum3  = fa_a3 ^ fa_b3 ^ fa_cin3;
  assign fa_cout3 = (fa_a3 & fa_b3) | (fa_a3 & fa_cin3) | (fa_b3 & fa_cin3);

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_m & ~sel), .in_ready(in_ready8),
    .a_in(a_m), .b_in(b_m), .cin_in(cin_m),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
    .out_valid(out_valid8), .out_ready(out_ready_m), .sum_out(sum8), .cout_out(cout8),
    .busy(busy8)
  );

  serial_add_seq #(.WIDTH(3)) u3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_m & sel), .in_ready(in_ready3),
    .a_in(a_m[2:0]), .b_in(b_m[2:0]), .cin_in(cin_m),
    .fa_a(fa_a3), .fa_b(fa_b3), .fa_cin(fa_cin3), .fa_sum(fa_sum3), .fa_cout(fa_cout3),
    .out_valid(out_valid3), .out_ready(out_ready_m), .sum_out(sum3), .cout_out(cout3),
    .busy(busy3)
  );

  assign m_in_ready  = sel ? in_ready3 : in_ready8;
  assign m_out_valid = sel ? out_valid3 : out_valid8;
  assign m_res       = sel ? {5'b0, cout3, sum3} : {cout8, sum8};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one WIDTH=8 operation and follows it until out_valid, logging fa_* per bit
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] va, output logic [7:0] vb, output logic [7:0] vc,
                        output int unsigned lat);
    a_m = a; b_m = b; cin_m = cin; in_valid_m = 1'b1;
    tick;
    in_valid_m = 1'b0;
    chk("op_busy", 32'(busy8), 32'(1));
    chk("op_in_ready", 32'(in_ready8), 32'(0));
    va = '0; vb = '0; vc = '0; lat = 0;
    while (!out_valid8 && lat < 20) begin
      if (lat < 8) begin
        va[lat] = fa_a8; vb[lat] = fa_b8; vc[lat] = fa_cin8;
      end
      lat++;
      tick;
    end
  endtask

  initial begin
    logic [7:0]  va, vb, vc;
    int unsigned lat;
    int unsigned wd;
    logic        saw;
    logic        done;
    logic [8:0]  exp_r;
    logic [8:0]  got_r;
    logic [7:0]  mask;
    logic [7:0]  ra, rb;
    logic        rc;

    rstn = 1'b0; sel = 1'b0; in_valid_m = 1'b0; out_ready_m = 1'b0;
    a_m = '0; b_m = '0; cin_m = 1'b0;
    tick; tick;
    chk("rst_in_ready", 32'(in_ready8), 32'(0));
    chk("rst_out_valid", 32'(out_valid8), 32'(0));
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_sum", 32'(sum8), 32'(0));
    chk("rst_cout", 32'(cout8), 32'(0));
    chk("rst_fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'(0));
    rstn = 1'b1;
    tick;
    chk("post_rst_in_ready", 32'(in_ready8), 32'(1));

    // 0x5A + 0x33 + 0
    out_ready_m = 1'b1;
    run_op(8'h5A, 8'h33, 1'b0, va, vb, vc, lat);
    chk("lat_5a33", 32'(lat), 32'(8));
    chk("ov_5a33", 32'(out_valid8), 32'(1));
    chk("sum_5a33", 32'(sum8), 32'h8D);
    chk("cout_5a33", 32'(cout8), 32'(0));
    chk("done_in_ready", 32'(in_ready8), 32'(0));
    tick;
    chk("ov_drop", 32'(out_valid8), 32'(0));
    chk("idle_in_ready", 32'(in_ready8), 32'(1));
    chk("idle_busy", 32'(busy8), 32'(0));
    chk("idle_sum_hold", 32'(sum8), 32'h8D);

    // Full carry ripple
    run_op(8'hFF, 8'h00, 1'b1, va, vb, vc, lat);
    chk("sum_ff00", 32'(sum8), 32'h00);
    chk("cout_ff00", 32'(cout8), 32'(1));
    tick;
    run_op(8'hFF, 8'hFF, 1'b1, va, vb, vc, lat);
    chk("sum_ffff", 32'(sum8), 32'hFF);
    chk("cout_ffff", 32'(cout8), 32'(1));
    tick;

    // Bit presentation, LSB first
    run_op(8'h81, 8'h01, 1'b0, va, vb, vc, lat);
    chk("fa_a_seq", 32'(va), 32'h81);
    chk("fa_b_seq", 32'(vb), 32'h01);
    chk("fa_cin_seq", 32'(vc), 32'h02);
    chk("sum_8101", 32'(sum8), 32'h82);
    chk("cout_8101", 32'(cout8), 32'(0));
    tick;

    // Backpressure in DONE with ignored in_valid pulses
    out_ready_m = 1'b0;
    run_op(8'h12, 8'h34, 1'b1, va, vb, vc, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid_m = 1'(i % 2); a_m = 8'hEE; b_m = 8'hEE; cin_m = 1'b1;
      tick;
      chk("bp_ov", 32'(out_valid8), 32'(1));
      chk("bp_sum", 32'(sum8), 32'h47);
      chk("bp_cout", 32'(cout8), 32'(0));
      chk("bp_in_ready", 32'(in_ready8), 32'(0));
    end
    in_valid_m = 1'b0; out_ready_m = 1'b1;
    tick;
    chk("bp_release_ov", 32'(out_valid8), 32'(0));
    chk("bp_release_rdy", 32'(in_ready8), 32'(1));
    tick;
    chk("bp_no_spurious", 32'(busy8), 32'(0));

    // Reset while presenting bit 3
    a_m = 8'hAA; b_m = 8'h55; cin_m = 1'b0; in_valid_m = 1'b1;
    tick;
    in_valid_m = 1'b0;
    tick; tick; tick;
    chk("midrst_bit3", 32'(fa_a8), 32'(1));
    rstn = 1'b0;
    tick;
    chk("midrst_in_ready", 32'(in_ready8), 32'(0));
    chk("midrst_ov", 32'(out_valid8), 32'(0));
    chk("midrst_busy", 32'(busy8), 32'(0));
    chk("midrst_sum", 32'(sum8), 32'(0));
    chk("midrst_cout", 32'(cout8), 32'(0));
    chk("midrst_fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'(0));
    rstn = 1'b1;
    tick;
    chk("midrst_rdy_back", 32'(in_ready8), 32'(1));
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw = saw | out_valid8;
      tick;
    end
    chk("midrst_no_ov", 32'(saw), 32'(0));
    run_op(8'h01, 8'h01, 1'b0, va, vb, vc, lat);
    chk("sum_0101", 32'(sum8), 32'h02);
    chk("cout_0101", 32'(cout8), 32'(0));
    tick;

    // Random traffic, WIDTH=8 then WIDTH=3
    for (int s = 0; s < 2; s++) begin
      sel  = 1'(s);
      mask = (s == 1) ? 8'h07 : 8'hFF;
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 3)) tick;
        ra = 8'($urandom) & mask;
        rb = 8'($urandom) & mask;
        rc = 1'($urandom);
        exp_r = ({1'b0, ra} + {1'b0, rb} + 9'(rc)) & ((s == 1) ? 9'h00F : 9'h1FF);
        a_m = ra; b_m = rb; cin_m = rc; in_valid_m = 1'b1;
        wd = 0;
        while (!m_in_ready && wd < 50) begin
          tick;
          wd++;
        end
        chk("rand_rdy", 32'(m_in_ready), 32'(1));
        tick;
        done = 1'b0; got_r = '0; wd = 0;
        while (!done && wd < 200) begin
          in_valid_m  = 1'($urandom);
          a_m         = 8'($urandom);
          out_ready_m = 1'($urandom);
          if (m_out_valid && out_ready_m) begin
            got_r = m_res;
            done  = 1'b1;
          end
          tick;
          wd++;
        end
        in_valid_m = 1'b0;
        chk("rand_done", 32'(done), 32'(1));
        chk("rand_result", 32'(got_r), 32'(exp_r));
        chk("rand_no_dup", 32'(m_out_valid), 32'(0));
      end
    end
    chk("end_idle8", 32'(busy8), 32'(0));
    chk("end_idle3", 32'(busy3), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
